imm_gen_stage: RTL

Pipelined, parametrised immediate generator for the decode stage. Accepts one instruction word plus PC per cycle over a valid/ready handshake. Emits, one cycle later, the sign- or zero-extended immediate, a format tag, an illegal-opcode flag and the PC-relative target. A 2-entry skid buffer decouples decode from backpressure by the execute stage, so throughput stays at one instruction per cycle.

---
 rtl/imm_gen_stage_if.sv | 29 ++
 rtl/imm_gen_stage.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for imm_gen_stage.
//   Input side : in_valid_i / in_ready_o carrying insn_i and pc_i.
//   Output side: out_valid_o / out_ready_i carrying the passed-through insn/pc
//                plus the decoded imm_o, target_o, fmt_o and illegal_o.
// modport slave is the stage itself; modport master is the decode/execute side.
interface imm_gen_stage_if #(parameter int DWIDTH = 32);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       insn_i;
  logic [DWIDTH-1:0] pc_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       insn_o;
  logic [DWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] imm_o;
  logic [DWIDTH-1:0] target_o;
  logic [2:0]        fmt_o;
  logic              illegal_o;

  modport slave (
    input  in_valid_i, insn_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, insn_o, pc_o, imm_o, target_o, fmt_o, illegal_o
  );

  modport master (
    output in_valid_i, insn_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, insn_o, pc_o, imm_o, target_o, fmt_o, illegal_o
  );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: one-cycle immediate generator for the decode stage.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; empties both entries
//   bus   : imm_gen_stage_if.slave (valid/ready in, valid/ready out)
// The decoded entry is registered into a main slot that drives the outputs;
// a second skid slot absorbs one extra entry when the consumer stalls, so
// in_ready_o can be a plain flop (!skid valid) with no path from out_ready_i.
module imm_gen_stage #(
  parameter int DWIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  imm_gen_stage_if.slave bus
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_Z = 3'd6;

  localparam logic [6:0] OP_LUI    = 7'b0110111, OP_AUIPC  = 7'b0010111,
                         OP_JAL    = 7'b1101111, OP_JALR   = 7'b1100111,
                         OP_LOAD   = 7'b0000011, OP_IMM    = 7'b0010011,
                         OP_MISC   = 7'b0001111, OP_STORE  = 7'b0100011,
                         OP_BRANCH = 7'b1100011, OP_OP     = 7'b0110011,
                         OP_IMM32  = 7'b0011011, OP_OP32   = 7'b0111011,
                         OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]       insn;
    logic [DWIDTH-1:0] pc;
    logic [DWIDTH-1:0] imm;
    logic [DWIDTH-1:0] target;
    logic [2:0]        fmt;
    logic              illegal;
  } entry_t;

  // ---------------- decode ----------------
  logic        [31:0]       insn;
  logic signed [31:0]       imm32;   // every RV immediate fits in 32 signed bits
  logic        [2:0]        fmt;
  logic                     ill;
  logic                     pcrel;
  logic        [DWIDTH-1:0] imm;
  entry_t                   dec;

  assign insn = bus.insn_i;

  always_comb begin
    imm32 = '0;
    fmt   = FMT_R;
    ill   = 1'b0;
    pcrel = 1'b0;
    case (insn[6:0])
      OP_LUI:    begin fmt = FMT_U; imm32 = {insn[31:12], 12'h000}; end
      OP_AUIPC:  begin fmt = FMT_U; imm32 = {insn[31:12], 12'h000}; pcrel = 1'b1; end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        pcrel = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_MISC: begin
        fmt = FMT_I; imm32 = {{20{insn[31]}}, insn[31:20]};
      end
      OP_STORE: begin
        fmt = FMT_S; imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        pcrel = 1'b1;
      end
      OP_OP:     fmt = FMT_R;
      OP_IMM32: begin
        if (DWIDTH == 64) begin fmt = FMT_I; imm32 = {{20{insn[31]}}, insn[31:20]}; end
        else ill = 1'b1;
      end
      OP_OP32:   ill = (DWIDTH != 64);
      OP_SYSTEM: begin
        // funct3[2] selects the CSR immediate forms (uimm in rs1 field)
        if (insn[14]) begin fmt = FMT_Z; imm32 = {27'b0, insn[19:15]}; end
        else begin fmt = FMT_I; imm32 = {{20{insn[31]}}, insn[31:20]}; end
      end
      default:   ill = 1'b1;
    endcase
    if (insn[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin
      imm32 = '0;
      fmt   = FMT_R;
      pcrel = 1'b0;
    end
  end

  // signed size cast sign-extends to DWIDTH (identity when DWIDTH == 32)
  assign imm = DWIDTH'(imm32);

  always_comb begin
    dec.insn    = insn;
    dec.pc      = bus.pc_i;
    dec.imm     = imm;
    dec.target  = pcrel ? bus.pc_i + imm : '0;  // wraps modulo 2^DWIDTH
    dec.fmt     = fmt;
    dec.illegal = ill;
  end

  // ---------------- main + skid storage ----------------
  entry_t main_q, skid_q;
  logic   main_vld, skid_vld;
  logic   accept, main_free;

  assign accept    = bus.in_valid_i && !skid_vld;
  assign main_free = !main_vld || bus.out_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (main_free) begin
      // skid holds the older entry; when it is full no accept is possible
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q   <= dec;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end

  assign bus.in_ready_o  = !skid_vld;
  assign bus.out_valid_o = main_vld;
  assign bus.insn_o      = main_q.insn;
  assign bus.pc_o        = main_q.pc;
  assign bus.imm_o       = main_q.imm;
  assign bus.target_o    = main_q.target;
  assign bus.fmt_o       = main_q.fmt;
  assign bus.illegal_o   = main_q.illegal;

endmodule
